mem_access: RTL and testbench

//  Memory-access stage: sits between execute and writeback and produces the MEM->WB

---
 rtl/mem_access.sv | 131 +++++++++++++
 tb/tb_mem_access.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage between execute and writeback
// Issues one aligned load/store per instruction on the data bus, lane-aligns store
// data/strobes, shifts and extends load data, and joins the global stall handshake.
// Ports:
//   clk, rst (async, active-low)
//   in_*                  instruction fields from execute, latched on a global advance
//   dreq_*                data-bus request (held stable until the transfer completes)
//   dresp_*               data-bus address/data acknowledge and raw load data
//   out_*                 MEM->WB fields, meaningful while the stage is DONE
//   ok_to_proceed         stage idle or finished
//   ok_to_proceed_overall global advance, AND of every stage's ok_to_proceed
module mem_access #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic            in_is_wb,
    input  logic [4:0]      in_wd,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            out_valid,
    output logic            out_is_wb,
    output logic [4:0]      out_wd,
    output logic [XLEN-1:0] out_alu_out,
    output logic [XLEN-1:0] out_mem_out,
    output logic [XLEN-1:0] out_mem_addr,
    output logic            out_is_mem_read,
    output logic            out_is_mem,
    output logic            out_misalign,
    output logic            ok_to_proceed,
    input  logic            ok_to_proceed_overall
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t          r_state, w_next;
    logic            r_valid, r_load, r_store, r_unsigned, r_is_wb, r_misalign;
    logic [1:0]      r_size;
    logic [4:0]      r_wd;
    logic [XLEN-1:0] r_addr, r_wdata, r_alu_out, r_mem_out;
    logic            w_accept, w_misalign, w_req, w_capture, w_sign;
    logic [2:0]      w_amask;
    logic [7:0]      w_mask;
    logic [XLEN-1:0] w_shifted, w_load;
    assign ok_to_proceed = (r_state == IDLE) || (r_state == DONE);
    assign w_accept      = ok_to_proceed && ok_to_proceed_overall;
    // Low address bits that must be zero for a naturally aligned access of in_size.
    assign w_amask       = {&in_size, in_size[1], |in_size};
    assign w_misalign    = |(in_addr[2:0] & w_amask);
    assign w_req         = (r_state == REQ) || (r_state == WAIT);
    assign w_capture     = ((r_state == REQ) && dresp_addr_ok && dresp_data_ok) ||
                           ((r_state == WAIT) && dresp_data_ok);
    assign w_mask        = (r_size == 2'd0) ? 8'h01 : (r_size == 2'd1) ? 8'h03 :
                           (r_size == 2'd2) ? 8'h0F : 8'hFF;
    assign w_shifted     = dresp_data >> {r_addr[2:0], 3'b000};
    assign w_sign        = ~r_unsigned & ((r_size == 2'd0) ? w_shifted[7] :
                                          (r_size == 2'd1) ? w_shifted[15] : w_shifted[31]);
    assign w_load        = (r_size == 2'd0) ? {{(XLEN-8){w_sign}}, w_shifted[7:0]} :
                           (r_size == 2'd1) ? {{(XLEN-16){w_sign}}, w_shifted[15:0]} :
                           (r_size == 2'd2) ? {{(XLEN-32){w_sign}}, w_shifted[31:0]} : w_shifted;
    assign dreq_valid      = w_req;
    assign dreq_addr       = r_addr;
    assign dreq_size       = {1'b0, r_size};
    assign dreq_strobe     = (w_req && r_store) ? 8'(w_mask << r_addr[2:0]) : 8'h00;
    assign dreq_data       = r_wdata << {r_addr[2:0], 3'b000};
    assign out_valid       = (r_state == DONE) && r_valid;
    assign out_is_wb       = r_is_wb;
    assign out_wd          = r_wd;
    assign out_alu_out     = r_alu_out;
    assign out_mem_out     = r_mem_out;
    assign out_mem_addr    = r_addr;
    assign out_is_mem_read = r_load;
    assign out_is_mem      = r_load | r_store;
    assign out_misalign    = r_misalign;
    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = (in_valid && (in_is_load || in_is_store) && !w_misalign) ? REQ : DONE;
        else if (r_state == REQ)
            w_next = dresp_addr_ok ? (dresp_data_ok ? DONE : WAIT) : REQ;
        else if (r_state == WAIT && dresp_data_ok)
            w_next = DONE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_is_wb    <= 1'b0;
            r_misalign <= 1'b0;
            r_size     <= '0;
            r_wd       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_alu_out  <= '0;
            r_mem_out  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_valid    <= in_valid;
                r_load     <= in_is_load;
                r_store    <= in_is_store;
                r_unsigned <= in_unsigned;
                r_is_wb    <= in_is_wb;
                r_misalign <= in_valid && (in_is_load || in_is_store) && w_misalign;
                r_size     <= in_size;
                r_wd       <= in_wd;
                r_addr     <= in_addr;
                r_wdata    <= in_wdata;
                r_alu_out  <= in_alu_out;
                r_mem_out  <= '0;
            end else if (w_capture && r_load) begin
                r_mem_out <= w_load;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for the memory-access stage
module tb_mem_access;
    logic        clk, rst;
    logic        in_valid, in_is_load, in_is_store, in_unsigned, in_is_wb;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata, in_alu_out;
    logic [4:0]  in_wd;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid, out_is_wb, out_is_mem_read, out_is_mem, out_misalign;
    logic [4:0]  out_wd;
    logic [63:0] out_alu_out, out_mem_out, out_mem_addr;
    logic        ok_to_proceed, ok_to_proceed_overall;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        v, ld, st, uns, wb;
        logic [1:0]  sz;
        logic [63:0] addr, wdata, rdata, alu;
        logic [4:0]  wd;
        int          aok, dok, poke, lat;
        logic [63:0] mem, ddata;
        logic [7:0]  strb;
        logic        mis;
    } op_t;
    op_t q[$];

    mem_access #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_alu_out(in_alu_out), .in_is_wb(in_is_wb), .in_wd(in_wd),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_is_wb(out_is_wb), .out_wd(out_wd),
        .out_alu_out(out_alu_out), .out_mem_out(out_mem_out), .out_mem_addr(out_mem_addr),
        .out_is_mem_read(out_is_mem_read), .out_is_mem(out_is_mem), .out_misalign(out_misalign),
        .ok_to_proceed(ok_to_proceed), .ok_to_proceed_overall(ok_to_proceed_overall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                               input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic [63:0] alu, input logic [4:0] wd,
                               input int aok, input int dok, input int poke, input int lat,
                               input logic [63:0] mem, input logic [63:0] ddata,
                               input logic [7:0] strb, input logic mis);
        op_t o;
        o.v = v; o.ld = ld; o.st = st; o.sz = sz; o.uns = uns; o.wb = ld | ~st;
        o.addr = addr; o.wdata = wdata; o.rdata = rdata; o.alu = alu; o.wd = wd;
        o.aok = aok; o.dok = dok; o.poke = poke; o.lat = lat;
        o.mem = mem; o.ddata = ddata; o.strb = strb; o.mis = mis;
        return o;
    endfunction

    // Drive one instruction with a single overall pulse, act as the bus, then check the result.
    task automatic do_op(input string t, input op_t o);
        op_t e;
        int lat = -1;
        int nreq = 0;
        @(negedge clk);
        in_valid = o.v; in_is_load = o.ld; in_is_store = o.st; in_size = o.sz;
        in_unsigned = o.uns; in_addr = o.addr; in_wdata = o.wdata; in_alu_out = o.alu;
        in_is_wb = o.wb; in_wd = o.wd; dresp_data = o.rdata;
        ok_to_proceed_overall = 1'b1;
        q.push_back(o);
        @(negedge clk);
        ok_to_proceed_overall = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (ok_to_proceed) begin
                lat = c;
                break;
            end
            if (dreq_valid) begin
                nreq++;
                chk({t, ".daddr"}, dreq_addr, o.addr);
                chk({t, ".dsize"}, 64'(dreq_size), {61'd0, 1'b0, o.sz});
                chk({t, ".strobe"}, 64'(dreq_strobe), 64'(o.strb));
                if (o.st) chk({t, ".ddata"}, dreq_data, o.ddata);
            end
            ok_to_proceed_overall = (c == o.poke);
            if (c == o.poke) begin
                in_addr = ~o.addr; in_wd = ~o.wd; in_alu_out = 64'hDEAD_BEEF; in_valid = 1'b0;
            end
            dresp_addr_ok = (c == o.aok);
            dresp_data_ok = (c == o.dok);
            @(negedge clk);
        end
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; ok_to_proceed_overall = 1'b0;
        e = q.pop_front();
        chk({t, ".lat"}, 64'(lat), 64'(e.lat));
        chk({t, ".nreq"}, 64'(nreq), 64'(e.lat - 1));
        chk({t, ".dreq_valid"}, 64'(dreq_valid), 64'd0);
        chk({t, ".valid"}, 64'(out_valid), 64'(e.v));
        chk({t, ".wd"}, 64'(out_wd), 64'(e.wd));
        chk({t, ".is_wb"}, 64'(out_is_wb), 64'(e.wb));
        chk({t, ".alu"}, out_alu_out, e.alu);
        chk({t, ".mem"}, out_mem_out, e.mem);
        chk({t, ".maddr"}, out_mem_addr, e.addr);
        chk({t, ".rd"}, 64'(out_is_mem_read), 64'(e.ld));
        chk({t, ".is_mem"}, 64'(out_is_mem), 64'(e.ld | e.st));
        chk({t, ".mis"}, 64'(out_misalign), 64'(e.mis));
    endtask

    initial begin
        rst = 1'b0; ok_to_proceed_overall = 1'b0;
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_size = 0; in_unsigned = 0;
        in_addr = 0; in_wdata = 0; in_alu_out = 0; in_is_wb = 0; in_wd = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
        repeat (2) @(negedge clk);
        chk("rst.ok", 64'(ok_to_proceed), 64'd1);
        chk("rst.dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst.strobe", 64'(dreq_strobe), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.alu", out_alu_out, 64'd0);
        chk("rst.mem", out_mem_out, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle.ok", 64'(ok_to_proceed), 64'd1);
        //        v  ld st sz uns addr           wdata                   rdata                   alu    wd   aok dok poke lat mem                     ddata                   strb   mis
        do_op("lb",   mk(1, 1, 0, 0, 0, 64'h1003, 64'h0,                 64'h0000_0000_80FF_0000, 64'h11, 5'd1, 1, 1, 0, 2, 64'hFFFF_FFFF_FFFF_FF80, 64'h0,                 8'h00, 0));
        do_op("lbu",  mk(1, 1, 0, 0, 1, 64'h1003, 64'h0,                 64'h0000_0000_80FF_0000, 64'h12, 5'd2, 1, 1, 0, 2, 64'h80,                  64'h0,                 8'h00, 0));
        do_op("sh",   mk(1, 0, 1, 1, 0, 64'h2006, 64'hABCD,              64'h0,                   64'h13, 5'd3, 1, 3, 0, 4, 64'h0,                   64'hABCD_0000_0000_0000, 8'hC0, 0));
        do_op("lw_mis", mk(1, 1, 0, 2, 0, 64'h3002, 64'h0,               64'h0,                   64'h14, 5'd4, 1, 1, 0, 1, 64'h0,                   64'h0,                 8'h00, 1));
        do_op("alu",  mk(1, 0, 0, 3, 0, 64'h0,    64'h0,                 64'h0,                   64'h5,  5'd7, 0, 0, 0, 1, 64'h0,                   64'h0,                 8'h00, 0));
        repeat (5) @(negedge clk);
        chk("hold.ok", 64'(ok_to_proceed), 64'd1);
        chk("hold.valid", 64'(out_valid), 64'd1);
        chk("hold.alu", out_alu_out, 64'h5);
        chk("hold.wd", 64'(out_wd), 64'd7);
        do_op("ld_poke", mk(1, 1, 0, 3, 0, 64'h4000, 64'h0,             64'h1122_3344_5566_7788, 64'h15, 5'd5, 3, 3, 1, 4, 64'h1122_3344_5566_7788, 64'h0,                 8'h00, 0));
        do_op("lh",   mk(1, 1, 0, 1, 0, 64'h5002, 64'h0,                 64'h0000_0000_8001_0000, 64'h16, 5'd6, 1, 2, 0, 3, 64'hFFFF_FFFF_FFFF_8001, 64'h0,                 8'h00, 0));
        do_op("lw",   mk(1, 1, 0, 2, 0, 64'h6004, 64'h0,                 64'h9ABC_DEF0_0000_0000, 64'h17, 5'd8, 2, 2, 0, 3, 64'hFFFF_FFFF_9ABC_DEF0, 64'h0,                 8'h00, 0));
        do_op("sb",   mk(1, 0, 1, 0, 0, 64'h7005, 64'h5A,                64'h0,                   64'h18, 5'd9, 1, 1, 0, 2, 64'h0,                   64'h0000_5A00_0000_0000, 8'h20, 0));
        do_op("sw",   mk(1, 0, 1, 2, 0, 64'h7004, 64'h1234_5678,         64'h0,                   64'h19, 5'd10, 1, 1, 0, 2, 64'h0,                  64'h1234_5678_0000_0000, 8'hF0, 0));
        do_op("sd",   mk(1, 0, 1, 3, 0, 64'h8000, 64'h0123_4567_89AB_CDEF, 64'h0,                 64'h1A, 5'd11, 2, 4, 0, 5, 64'h0,                  64'h0123_4567_89AB_CDEF, 8'hFF, 0));
        do_op("sh_mis", mk(1, 0, 1, 1, 0, 64'h2001, 64'hFFFF,            64'h0,                   64'h1B, 5'd12, 1, 1, 0, 1, 64'h0,                  64'h0,                 8'h00, 1));
        do_op("bubble", mk(0, 0, 0, 0, 0, 64'h9000, 64'h0,               64'h0,                   64'h9,  5'd3, 0, 0, 0, 1, 64'h0,                   64'h0,                 8'h00, 0));
        // Reset while a store is waiting for its data acknowledge.
        @(negedge clk);
        in_valid = 1; in_is_load = 0; in_is_store = 1; in_size = 2; in_addr = 64'hA000;
        in_wdata = 64'h1; ok_to_proceed_overall = 1'b1;
        @(negedge clk);
        ok_to_proceed_overall = 1'b0; dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        chk("wait.dreq_valid", 64'(dreq_valid), 64'd1);
        chk("wait.ok", 64'(ok_to_proceed), 64'd0);
        rst = 1'b0;
        #1;
        chk("async.dreq_valid", 64'(dreq_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("rst2.dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst2.ok", 64'(ok_to_proceed), 64'd1);
        chk("rst2.out_valid", 64'(out_valid), 64'd0);
        chk("rst2.strobe", 64'(dreq_strobe), 64'd0);
        @(negedge clk);
        chk("idle2.dreq_valid", 64'(dreq_valid), 64'd0);
        do_op("after_rst", mk(1, 1, 0, 0, 1, 64'hB007, 64'h0,            64'hFE00_0000_0000_0000, 64'h1C, 5'd13, 1, 1, 0, 2, 64'hFE,                 64'h0,                 8'h00, 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
